seq_divider: RTL and testbench

//  Multi-cycle iterative restoring divider returning quotient and remainder.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 176 +++++++++++++++++
 tb/tb_seq_divider.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Divide-by-zero quotient is this bit replicated across the result width.
    localparam logic DZ_Q_BIT  = 1'b1;
    localparam logic DZ_FLAG   = 1'b1;

    function automatic int unsigned div_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {p,a} left, trial-subtract b.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] a_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // p < b always holds, so the restored or trial remainder fits in WIDTH bits.
    assign shifted = {p_i, a_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, b_i};
    assign p_o     = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign a_o     = {a_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with valid/ready operand and result handshakes,
// optional two's-complement mode and a divide-by-zero flag.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned UNROLL    = 1,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dz
);

    localparam int unsigned N     = WIDTH / UNROLL;
    localparam int unsigned CNT_W = div_cnt_width(N);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q_q, out_q_d;
    logic [WIDTH-1:0] out_r_q, out_r_d;
    logic             out_dz_q, out_dz_d;

    logic             accept;
    logic             signed_mode;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] p_step;
    logic [WIDTH-1:0] a_step;

    assign accept      = in_valid && in_ready_q;
    assign signed_mode = SIGNED_EN && in_signed;
    assign a_neg       = signed_mode && in_a[WIDTH-1];
    assign b_neg       = signed_mode && in_b[WIDTH-1];
    assign b_zero      = (in_b == '0);

    // UNROLL restoring steps chained per clock.
    for (genvar i = 0; i < UNROLL; i++) begin : g_stage
        logic [WIDTH-1:0] p_in, a_in, p_out, a_out;
        if (i == 0) begin : g_first
            assign p_in = p_q;
            assign a_in = a_q;
        end else begin : g_next
            assign p_in = g_stage[i-1].p_out;
            assign a_in = g_stage[i-1].a_out;
        end
        div_step #(.WIDTH(WIDTH)) u_step (
            .p_i (p_in),
            .a_i (a_in),
            .b_i (b_q),
            .p_o (p_out),
            .a_o (a_out)
        );
    end

    assign p_step = g_stage[UNROLL-1].p_out;
    assign a_step = g_stage[UNROLL-1].a_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
            out_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            a_q         <= a_d;
            b_q         <= b_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_r_q     <= out_r_d;
            out_dz_q    <= out_dz_d;
        end
    end

    // FIX lasts until the counter is non-zero, which gives divide-by-zero a fixed two-cycle latency.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = b_zero ? FIX : CALC;
            CALC: if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
            FIX:  if (cnt_q != '0) state_d = DONE;
            DONE: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        p_d         = p_q;
        a_d         = a_q;
        b_d         = b_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        out_q_d     = out_q_q;
        out_r_d     = out_r_q;
        out_dz_d    = out_dz_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Divide-by-zero keeps the raw dividend so it can be returned as the remainder.
                    a_d     = (a_neg && !b_zero) ? -in_a : in_a;
                    b_d     = b_neg ? -in_b : in_b;
                    p_d     = '0;
                    cnt_d   = '0;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = b_zero;
                end
            end
            CALC: begin
                p_d   = p_step;
                a_d   = a_step;
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIX: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else if (dz_q) begin
                    out_q_d  = {WIDTH{DZ_Q_BIT}};
                    out_r_d  = a_q;
                    out_dz_d = DZ_FLAG;
                end else begin
                    out_q_d  = q_neg_q ? -a_q : a_q;
                    out_r_d  = r_neg_q ? -p_q : p_q;
                    out_dz_d = 1'b0;
                end
            end
            DONE: ;
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign out_dz    = out_dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: a UNROLL=1 and a UNROLL=4 instance.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_v  [2];
    logic        in_ready_v  [2];
    logic [31:0] in_a_v      [2];
    logic [31:0] in_b_v      [2];
    logic        in_signed_v [2];
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic [31:0] out_q_v     [2];
    logic [31:0] out_r_v     [2];
    logic        out_dz_v    [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32), .UNROLL(1), .SIGNED_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_v[0]),
        .in_ready  (in_ready_v[0]),
        .in_a      (in_a_v[0]),
        .in_b      (in_b_v[0]),
        .in_signed (in_signed_v[0]),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready_v[0]),
        .out_q     (out_q_v[0]),
        .out_r     (out_r_v[0]),
        .out_dz    (out_dz_v[0])
    );

    seq_divider #(.WIDTH(32), .UNROLL(4), .SIGNED_EN(1'b1)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_v[1]),
        .in_ready  (in_ready_v[1]),
        .in_a      (in_a_v[1]),
        .in_b      (in_b_v[1]),
        .in_signed (in_signed_v[1]),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready_v[1]),
        .out_q     (out_q_v[1]),
        .out_r     (out_r_v[1]),
        .out_dz    (out_dz_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Present operands for one edge; afterwards scramble them to show they are ignored.
    task automatic accept_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                             input logic sg);
        check("in_ready_before_accept", 32'(in_ready_v[sel]), 32'd1);
        in_a_v[sel]      = a;
        in_b_v[sel]      = b;
        in_signed_v[sel] = sg;
        in_valid_v[sel]  = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[sel]  = 1'b0;
        in_a_v[sel]      = 32'hDEAD_BEEF;
        in_b_v[sel]      = 32'h0000_0005;
        in_signed_v[sel] = ~sg;
    endtask

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_result(input int sel, input int lat, input logic [31:0] q,
                               input logic [31:0] r, input logic dz);
        int n;
        n = 0;
        while (out_valid_v[sel] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("result_latency", 32'(n), 32'(lat));
        check("quotient", out_q_v[sel], q);
        check("remainder", out_r_v[sel], r);
        check("dz_flag", 32'(out_dz_v[sel]), 32'(dz));
    endtask

    task automatic pop(input int sel);
        out_ready_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[sel] = 1'b0;
        check("pop_out_valid", 32'(out_valid_v[sel]), 32'd0);
        check("pop_in_ready", 32'(in_ready_v[sel]), 32'd1);
    endtask

    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input int lat, input logic [31:0] q,
                          input logic [31:0] r, input logic dz);
        accept_op(sel, a, b, sg);
        wait_result(sel, lat, q, r, dz);
        pop(sel);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 2; i++) begin
            in_valid_v[i]  = 1'b0;
            in_a_v[i]      = '0;
            in_b_v[i]      = '0;
            in_signed_v[i] = 1'b0;
            out_ready_v[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", 32'(in_ready_v[i]), 32'd1);
            check("rst_out_valid", 32'(out_valid_v[i]), 32'd0);
            check("rst_out_q", out_q_v[i], 32'd0);
            check("rst_out_r", out_r_v[i], 32'd0);
            check("rst_out_dz", 32'(out_dz_v[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(0, 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
        run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run_op(0, 32'h1234_5678, 32'd0, 1'b0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0);

        // Backpressure: result must hold while out_ready is low, and no accept happens.
        accept_op(0, 32'd1000, 32'd10, 1'b0);
        wait_result(0, 33, 32'd100, 32'd0, 1'b0);
        in_a_v[0]     = 32'd50;
        in_b_v[0]     = 32'd7;
        in_signed_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid_v[0]), 32'd1);
            check("bp_in_ready", 32'(in_ready_v[0]), 32'd0);
            check("bp_out_q", out_q_v[0], 32'd100);
            check("bp_out_r", out_r_v[0], 32'd0);
        end
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        check("bp_release_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("bp_release_in_ready", 32'(in_ready_v[0]), 32'd1);
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        check("bp_next_accepted", 32'(in_ready_v[0]), 32'd0);
        wait_result(0, 33, 32'd7, 32'd1, 1'b0);
        pop(0);

        // Reset during CALC aborts silently and clears the outputs.
        accept_op(0, 32'h0000_FFFF, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready_v[0]), 32'd1);
        check("abort_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("abort_out_q", out_q_v[0], 32'd0);
        check("abort_out_r", out_r_v[0], 32'd0);
        check("abort_out_dz", 32'(out_dz_v[0]), 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid_v[0] === 1'b1) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op(0, 32'd9, 32'd3, 1'b0, 33, 32'd3, 32'd0, 1'b0);

        run_op(1, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 9, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
        run_op(1, 32'hFFFF_FF9C, 32'd7, 1'b1, 9, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_op(1, 32'hCAFE_0001, 32'd0, 1'b1, 2, 32'hFFFF_FFFF, 32'hCAFE_0001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
